// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Bundles the fetch handshake, the data-memory request and the
//             RFplusALU control strobes driven by multicycle_ctrl.
//  Modports : master - controller side (drives strobes, ins_ready, mem_req)
//             slave  - datapath / fetch / memory side (drives Ins, ins_valid,
//                      mem_ack)
//  Signals  : Ins[15:0], ins_valid, ins_ready          fetch handshake
//             mem_req, mem_we, mem_ack                 data-memory access
//             WBRF, WBresource, RBresource, OprandB,
//             LI, Buff_IDEXE                           RF / ID strobes
//             PSW_C, ALUop, Flag, psw_we               EXE ALU controls
//             illegal, mem_err, halted                 status
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [15:0] Ins;
    logic        ins_valid;
    logic        ins_ready;

    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;

    logic        WBRF;
    logic        WBresource;
    logic        RBresource;
    logic        OprandB;
    logic        LI;
    logic        Buff_IDEXE;

    logic        PSW_C;
    logic        ALUop;
    logic        Flag;
    logic        psw_we;

    logic        illegal;
    logic        mem_err;
    logic        halted;

    modport master (
        input  Ins, ins_valid, mem_ack,
        output ins_ready, mem_req, mem_we,
        output WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE,
        output PSW_C, ALUop, Flag, psw_we,
        output illegal, mem_err, halted
    );

    modport slave (
        output Ins, ins_valid, mem_ack,
        input  ins_ready, mem_req, mem_we,
        input  WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE,
        input  PSW_C, ALUop, Flag, psw_we,
        input  illegal, mem_err, halted
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multicycle FETCH/ID/EXE/MEM/WB controller for the RFplusALU
//             datapath. Takes one instruction at a time, decodes Ins[15:11]
//             and drives every control strobe plus the data-memory request.
//  Params   : MEM_TIMEOUT - max MEM cycles waiting for mem_ack (0 = forever)
//  Ports    : clk    - system clock, rising edge
//             Reset  - synchronous active-high reset
//             bus    - multicycle_ctrl_if.master (handshake, memory, strobes)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic          clk,
    input  wire logic          Reset,
    multicycle_ctrl_if.master  bus
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [4:0] c_OP_LHI    = 5'b00001;
    localparam logic [4:0] c_OP_LLI    = 5'b00010;
    localparam logic [4:0] c_OP_LDR_RI = 5'b00011;
    localparam logic [4:0] c_OP_LDR_RR = 5'b00100;
    localparam logic [4:0] c_OP_STR_RI = 5'b00101;
    localparam logic [4:0] c_OP_STR_RR = 5'b00110;
    localparam logic [4:0] c_OP_ADD    = 5'b00111;
    localparam logic [4:0] c_OP_ADC    = 5'b01000;
    localparam logic [4:0] c_OP_SUB    = 5'b01001;
    localparam logic [4:0] c_OP_SBB    = 5'b01010;
    localparam logic [4:0] c_OP_CMP    = 5'b01011;
    localparam logic [4:0] c_OP_ADDI   = 5'b01100;
    localparam logic [4:0] c_OP_SUBI   = 5'b01101;
    localparam logic [4:0] c_OP_HLT    = 5'b11111;

    // Counter only ever needs to reach MEM_TIMEOUT-1.
    localparam int c_CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam bit c_TO_EN = (MEM_TIMEOUT > 0);

    // ------------------------------------------------------------------
    // State and registered-output types
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_ID    = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    typedef struct packed {
        logic ins_ready;
        logic mem_req;
        logic mem_we;
        logic wbrf;
        logic wbresource;
        logic rbresource;
        logic oprandb;
        logic li;
        logic buff_idexe;
        logic psw_c;
        logic aluop;
        logic flag;
        logic psw_we;
        logic illegal;
        logic halted;
    } ctrl_out_t;

    // ------------------------------------------------------------------
    // Opcode class helpers
    // ------------------------------------------------------------------
    function automatic logic f_is_ldr(input logic [4:0] op);
        return (op == c_OP_LDR_RI) || (op == c_OP_LDR_RR);
    endfunction

    function automatic logic f_is_str(input logic [4:0] op);
        return (op == c_OP_STR_RI) || (op == c_OP_STR_RR);
    endfunction

    // Immediate-operand group: OprandB selects the immediate in ID.
    function automatic logic f_is_ri(input logic [4:0] op);
        return (op == c_OP_LDR_RI) || (op == c_OP_STR_RI) ||
               (op == c_OP_ADDI)   || (op == c_OP_SUBI);
    endfunction

    function automatic logic f_is_rr(input logic [4:0] op);
        return (op == c_OP_LDR_RR) || (op == c_OP_STR_RR) ||
               (op == c_OP_ADD)    || (op == c_OP_ADC)    ||
               (op == c_OP_SUB)    || (op == c_OP_SBB)    ||
               (op == c_OP_CMP);
    endfunction

    // Instructions whose ALU result updates the PSW flags.
    function automatic logic f_sets_psw(input logic [4:0] op);
        return (op == c_OP_ADD)  || (op == c_OP_ADC)  ||
               (op == c_OP_SUB)  || (op == c_OP_SBB)  ||
               (op == c_OP_CMP)  || (op == c_OP_ADDI) ||
               (op == c_OP_SUBI);
    endfunction

    // ------------------------------------------------------------------
    // Next-state helpers for the opcode-dependent transitions
    // ------------------------------------------------------------------
    function automatic state_t f_next_id(input logic [4:0] op);
        state_t ns;
        if ((op == c_OP_LHI) || (op == c_OP_LLI)) begin
            ns = S_WB;
        end else if (f_is_ri(op) || f_is_rr(op)) begin
            ns = S_EXE;
        end else if (op == c_OP_HLT) begin
            ns = S_HALT;
        end else begin
            ns = S_FETCH;
        end
        return ns;
    endfunction

    function automatic state_t f_next_exe(input logic [4:0] op);
        state_t ns;
        if (f_is_ldr(op) || f_is_str(op)) begin
            ns = S_MEM;
        end else if (op == c_OP_CMP) begin
            ns = S_FETCH;
        end else begin
            ns = S_WB;
        end
        return ns;
    endfunction

    // ------------------------------------------------------------------
    // Moore output decode: the value every output takes while sitting in
    // state s with opcode op latched. Evaluated for the state being
    // entered so the outputs come straight from flops.
    // ------------------------------------------------------------------
    function automatic ctrl_out_t f_decode(input state_t s, input logic [4:0] op);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.ins_ready = 1'b1;
            end
            S_ID: begin
                if (op == c_OP_LHI) begin
                    o.rbresource = 1'b1;
                    o.buff_idexe = 1'b1;
                end else if (op == c_OP_LLI) begin
                    o.li         = 1'b1;
                    o.buff_idexe = 1'b1;
                end else if (f_is_ri(op)) begin
                    o.oprandb    = 1'b1;
                    o.buff_idexe = 1'b1;
                end else if (f_is_rr(op)) begin
                    o.buff_idexe = 1'b1;
                end else if (op != c_OP_HLT) begin
                    o.illegal    = 1'b1;
                end
            end
            S_EXE: begin
                // Store data is read from RF[Ins[10:8]] through port B.
                o.rbresource = f_is_str(op);
                o.psw_we     = f_sets_psw(op);
                case (op)
                    c_OP_ADC:                      {o.psw_c, o.aluop, o.flag} = 3'b101;
                    c_OP_SUB, c_OP_CMP, c_OP_SUBI: {o.psw_c, o.aluop, o.flag} = 3'b010;
                    c_OP_SBB:                      {o.psw_c, o.aluop, o.flag} = 3'b011;
                    default:                       {o.psw_c, o.aluop, o.flag} = 3'b100;
                endcase
            end
            S_MEM: begin
                o.mem_req = 1'b1;
                o.mem_we  = f_is_str(op);
            end
            S_WB: begin
                o.wbrf       = 1'b1;
                // Loads write back memory data, everything else the ALU/LI result.
                o.wbresource = ~f_is_ldr(op);
            end
            S_HALT: begin
                o.halted = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [4:0]         r_op;
    logic [c_CNT_W-1:0] r_cnt;
    ctrl_out_t          r_out;

    // Timeout fires only when the final allowed MEM cycle ends without an
    // ack; an ack in that same cycle takes priority. This is the one output
    // that depends on an input directly, so the pulse lands in the last
    // MEM cycle itself.
    logic w_timeout;
    assign w_timeout = c_TO_EN && (r_state == S_MEM) && !bus.mem_ack &&
                       (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_cnt   <= '0;
            r_out   <= f_decode(S_FETCH, 5'b00000);
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.ins_valid) begin
                        r_state <= S_ID;
                        r_op    <= bus.Ins[15:11];
                        r_out   <= f_decode(S_ID, bus.Ins[15:11]);
                    end
                end
                S_ID: begin
                    r_state <= f_next_id(r_op);
                    r_out   <= f_decode(f_next_id(r_op), r_op);
                end
                S_EXE: begin
                    r_state <= f_next_exe(r_op);
                    r_out   <= f_decode(f_next_exe(r_op), r_op);
                    r_cnt   <= '0;
                end
                S_MEM: begin
                    if (bus.mem_ack) begin
                        r_cnt <= '0;
                        if (f_is_ldr(r_op)) begin
                            r_state <= S_WB;
                            r_out   <= f_decode(S_WB, r_op);
                        end else begin
                            r_state <= S_FETCH;
                            r_out   <= f_decode(S_FETCH, r_op);
                        end
                    end else if (w_timeout) begin
                        // Abandon the access; a timed-out load never writes back.
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                        r_out   <= f_decode(S_FETCH, r_op);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_out   <= f_decode(S_FETCH, r_op);
                end
                S_HALT: begin
                    // Sticky: only Reset leaves HALT.
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                    r_out   <= f_decode(S_FETCH, r_op);
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.ins_ready  = r_out.ins_ready;
    assign bus.mem_req    = r_out.mem_req;
    assign bus.mem_we     = r_out.mem_we;
    assign bus.WBRF       = r_out.wbrf;
    assign bus.WBresource = r_out.wbresource;
    assign bus.RBresource = r_out.rbresource;
    assign bus.OprandB    = r_out.oprandb;
    assign bus.LI         = r_out.li;
    assign bus.Buff_IDEXE = r_out.buff_idexe;
    assign bus.PSW_C      = r_out.psw_c;
    assign bus.ALUop      = r_out.aluop;
    assign bus.Flag       = r_out.flag;
    assign bus.psw_we     = r_out.psw_we;
    assign bus.illegal    = r_out.illegal;
    assign bus.halted     = r_out.halted;
    assign bus.mem_err    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Directed self-checking bench for multicycle_ctrl. Walks ADD,
//             LHI/LLI, LDR with delayed ack, STR timeout, illegal, HLT,
//             SBB/CMP back-to-back and reset during MEM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic clk;
    logic Reset;
    int   n_assert;
    int   n_fail;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {WBRF,WBresource,RBresource,OprandB,LI,Buff_IDEXE}
    function automatic logic [5:0] strb();
        return {bus.WBRF, bus.WBresource, bus.RBresource,
                bus.OprandB, bus.LI, bus.Buff_IDEXE};
    endfunction

    // {PSW_C,ALUop,Flag}
    function automatic logic [2:0] code();
        return {bus.PSW_C, bus.ALUop, bus.Flag};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one accepting edge.
    task automatic issue(input logic [15:0] ins);
        bus.Ins       = ins;
        bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0;
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        Reset         = 1'b1;
        bus.Ins       = 16'h0000;
        bus.ins_valid = 1'b0;
        bus.mem_ack   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_ins_ready", {15'd0, bus.ins_ready}, 16'd1);
        chk("rst_strb",      {10'd0, strb()},        16'd0);
        chk("rst_code",      {13'd0, code()},        16'd0);
        chk("rst_status",    {12'd0, bus.mem_req, bus.illegal, bus.mem_err, bus.halted}, 16'd0);
        Reset = 1'b0;
        tick();
        chk("idle_ins_ready", {15'd0, bus.ins_ready}, 16'd1);

        // ---------------- 1: ADD ----------------
        issue(16'h394C);
        chk("add_id_strb",   {10'd0, strb()},        16'b000001);
        chk("add_id_ready",  {15'd0, bus.ins_ready}, 16'd0);
        tick();
        chk("add_exe_code",  {13'd0, code()},        16'b100);
        chk("add_exe_pswwe", {15'd0, bus.psw_we},    16'd1);
        chk("add_exe_strb",  {10'd0, strb()},        16'b000000);
        tick();
        chk("add_wb_strb",   {10'd0, strb()},        16'b110000);
        chk("add_wb_pswwe",  {15'd0, bus.psw_we},    16'd0);
        tick();
        chk("add_lat4_ready", {15'd0, bus.ins_ready}, 16'd1);

        // ---------------- LHI / LLI (latency 3) ----------------
        issue(16'h0800);
        chk("lhi_id_strb", {10'd0, strb()}, 16'b001001);
        tick();
        chk("lhi_wb_strb", {10'd0, strb()}, 16'b110000);
        tick();
        chk("lhi_lat3_ready", {15'd0, bus.ins_ready}, 16'd1);
        issue(16'h1000);
        chk("lli_id_strb", {10'd0, strb()}, 16'b000011);
        tick();
        chk("lli_wb_strb", {10'd0, strb()}, 16'b110000);
        tick();

        // ---------------- 2: LDR_RI, ack on 3rd MEM cycle ----------------
        issue(16'h1A25);
        chk("ldr_id_strb",   {10'd0, strb()},     16'b000101);
        tick();
        chk("ldr_exe_code",  {13'd0, code()},     16'b100);
        chk("ldr_exe_pswwe", {15'd0, bus.psw_we}, 16'd0);
        tick();
        chk("ldr_mem1_req",  {14'd0, bus.mem_req, bus.mem_we}, 16'b10);
        tick();
        chk("ldr_mem2_req",  {15'd0, bus.mem_req}, 16'd1);
        tick();
        chk("ldr_mem3_req",  {15'd0, bus.mem_req}, 16'd1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("ldr_wb_req",    {15'd0, bus.mem_req}, 16'd0);
        chk("ldr_wb_strb",   {10'd0, strb()},      16'b100000);
        tick();
        chk("ldr_fetch_ready", {15'd0, bus.ins_ready}, 16'd1);

        // ---------------- 3: STR_RR, no ack -> timeout ----------------
        issue(16'h3000);
        chk("strrr_id_strb", {10'd0, strb()}, 16'b000001);
        tick();
        chk("strrr_exe_strb", {10'd0, strb()}, 16'b001000);
        chk("strrr_exe_code", {13'd0, code()}, 16'b100);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("strrr_mem%0d_req_we", i), {14'd0, bus.mem_req, bus.mem_we}, 16'b11);
            chk($sformatf("strrr_mem%0d_err", i),    {15'd0, bus.mem_err}, (i == 16) ? 16'd1 : 16'd0);
            chk($sformatf("strrr_mem%0d_wbrf", i),   {15'd0, bus.WBRF}, 16'd0);
        end
        tick();
        chk("strrr_to_fetch", {13'd0, bus.ins_ready, bus.mem_req, bus.mem_err}, 16'b100);
        chk("strrr_to_wbrf",  {15'd0, bus.WBRF}, 16'd0);

        // ---------------- 4: illegal then HLT ----------------
        issue(16'h8000);
        chk("ill_id_pulse", {15'd0, bus.illegal}, 16'd1);
        chk("ill_id_strb",  {10'd0, strb()},      16'b000000);
        tick();
        chk("ill_fetch", {14'd0, bus.ins_ready, bus.illegal}, 16'b10);
        issue(16'hF800);
        chk("hlt_id_strb", {10'd0, strb()}, 16'd0);
        chk("hlt_id_ill",  {15'd0, bus.illegal}, 16'd0);
        bus.Ins       = 16'h394C;
        bus.ins_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hlt_halt%0d", i), {14'd0, bus.halted, bus.ins_ready}, 16'b10);
            chk($sformatf("hlt_strb%0d", i), {7'd0, strb(), code()}, 16'd0);
        end
        bus.ins_valid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("hlt_reset", {14'd0, bus.halted, bus.ins_ready}, 16'b01);

        // ---------------- 5: SBB then CMP back-to-back ----------------
        issue(16'h5000);
        chk("sbb_id_strb", {10'd0, strb()}, 16'b000001);
        tick();
        chk("sbb_exe_code", {12'd0, code(), bus.psw_we}, 16'b0111);
        tick();
        chk("sbb_wb_strb", {10'd0, strb()}, 16'b110000);
        tick();
        chk("sbb_fetch", {15'd0, bus.ins_ready}, 16'd1);
        issue(16'h5800);
        chk("cmp_id_strb", {10'd0, strb()}, 16'b000001);
        tick();
        chk("cmp_exe_code", {12'd0, code(), bus.psw_we}, 16'b0101);
        tick();
        chk("cmp_fetch", {14'd0, bus.ins_ready, bus.WBRF}, 16'b10);

        // ---------------- 6: reset during MEM of STR ----------------
        issue(16'h2800);
        chk("strri_id_strb", {10'd0, strb()}, 16'b000101);
        tick();
        tick();
        chk("strri_mem_req", {14'd0, bus.mem_req, bus.mem_we}, 16'b11);
        Reset = 1'b1;
        tick();
        chk("rstmem_bus", {13'd0, bus.mem_req, bus.mem_we, bus.ins_ready}, 16'b001);
        chk("rstmem_strb", {7'd0, strb(), code()}, 16'd0);
        Reset = 1'b0;
        tick();
        chk("rstmem_idle", {14'd0, bus.ins_ready, bus.mem_req}, 16'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
